// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and state encoding for the 8-to-1 mux scan controller.
package mux_scan_ctrl_pkg;

  localparam int SEL_W      = 3;
  localparam int NUM_IN     = 8;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable down-counter that paces how long each select value is held.
module settle_timer
  import mux_scan_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a downstream 8-to-1 mux through all inputs and assembles the samples
// into one word; optionally rescans back-to-back.
//
// state  | meaning
// IDLE   | selects parked at 000, waiting for start
// SETTLE | select lines held on current index while the mux output settles
// SAMPLE | capture mux output into shadow[index], advance or finish
// DONE   | publish shadow to word, pulse done, rescan if continuous
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              mux_o,
  output logic              s0,
  output logic              s1,
  output logic              s2,
  output logic [NUM_IN-1:0] word,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  scan_state_e       state_q;
  logic [SEL_W-1:0]  idx_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NUM_IN-1:0] shadow_q;
  logic [NUM_IN-1:0] word_q;
  logic              busy_q;
  logic              done_q;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;

  // The timer is reloaded on every edge that enters SETTLE.
  assign tmr_load = ((state_q == ST_IDLE)   && start) ||
                    ((state_q == ST_SAMPLE) && (idx_q != LAST_IDX)) ||
                    ((state_q == ST_DONE)   && continuous);
  assign tmr_dec  = (state_q == ST_SETTLE);

  settle_timer u_settle_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SETTLE;
            idx_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          shadow_q[idx_q] <= mux_o;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_SETTLE;
            idx_q   <= idx_q + 1'b1;
            sel_q   <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          // Whole-word publish: word never exposes a partial scan.
          word_q  <= shadow_q;
          done_q  <= 1'b1;
          idx_q   <= '0;
          sel_q   <= '0;
          if (continuous) begin
            state_q <= ST_SETTLE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s0   = sel_q[2];
  assign s1   = sel_q[1];
  assign s2   = sel_q[0];
  assign word = word_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench: two instances (settle 1 and 3) against a timing model.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] inp = 8'h69;

  logic       a_s0, a_s1, a_s2, a_busy, a_done, a_mux;
  logic [7:0] a_word;
  logic       b_s0, b_s1, b_s2, b_busy, b_done, b_mux;
  logic [7:0] b_word;

  logic [2:0] a_sel, b_sel;
  assign a_sel = {a_s0, a_s1, a_s2};
  assign b_sel = {b_s0, b_s1, b_s2};
  assign a_mux = inp[a_sel];
  assign b_mux = inp[b_sel];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mux_o(a_mux),
    .s0(a_s0), .s1(a_s1), .s2(a_s2), .word(a_word), .busy(a_busy), .done(a_done)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mux_o(b_mux),
    .s0(b_s0), .s1(b_s1), .s2(b_s2), .word(b_word), .busy(b_busy), .done(b_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scan model: t counts edges since the scan began; a scan spans 8*(S+1)
  // busy cycles plus one DONE cycle, the word appearing on the edge after.
  typedef struct {
    bit         active;
    int         t;
    logic [7:0] shadow;
    logic [7:0] word;
    bit         done;
  } model_t;

  function automatic model_t step(model_t m, int s, bit st, bit cont, logic [7:0] in_v);
    int blen;
    int i;
    blen = 8 * (s + 1);
    m.done = 1'b0;
    if (!m.active) begin
      if (st) begin
        m.active = 1'b1;
        m.t = 0;
      end
    end else begin
      if (m.t < blen && (m.t % (s + 1)) == s) begin
        i = m.t / (s + 1);
        m.shadow[i] = in_v[i];
      end
      m.t++;
      if (m.t == blen + 1) begin
        m.word = m.shadow;
        m.done = 1'b1;
        if (cont) m.t = 0;
        else m.active = 1'b0;
      end
    end
    return m;
  endfunction

  function automatic int exp_sel(model_t m, int s);
    if (!m.active) return 0;
    if (m.t < 8 * (s + 1)) return m.t / (s + 1);
    return 7;
  endfunction

  function automatic int exp_busy(model_t m, int s);
    return (m.active && m.t < 8 * (s + 1)) ? 1 : 0;
  endfunction

  model_t ma, mb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = '{active: 1'b0, t: 0, shadow: 8'h00, word: 8'h00, done: 1'b0};
      mb = '{active: 1'b0, t: 0, shadow: 8'h00, word: 8'h00, done: 1'b0};
    end else begin
      ma = step(ma, 1, start, continuous, inp);
      mb = step(mb, 3, start, continuous, inp);
    end
  end

  int cyc = 0;
  int a_cnt = 0, b_cnt = 0;
  int a_last = -1, b_last = -1;
  int a_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("a_sel",  int'(a_sel),  exp_sel(ma, 1));
      chk("a_busy", int'(a_busy), exp_busy(ma, 1));
      chk("a_done", int'(a_done), int'(ma.done));
      chk("a_word", int'(a_word), int'(ma.word));
      chk("b_sel",  int'(b_sel),  exp_sel(mb, 3));
      chk("b_busy", int'(b_busy), exp_busy(mb, 3));
      chk("b_done", int'(b_done), int'(mb.done));
      chk("b_word", int'(b_word), int'(mb.word));
      if (a_done) begin
        a_cnt++;
        if (a_last >= 0) a_gap = cyc - a_last;
        a_last = cyc;
      end
      if (b_done) begin
        b_cnt++;
        b_last = cyc;
      end
    end
  end

  int s_cyc;

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base_a, base_b;

  initial begin
    wait_neg(3);
    chk("rst_sel",  int'(a_sel),  0);
    chk("rst_word", int'(a_word), 8'h00);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(b_done), 0);
    rst = 1'b0;

    // single scan, both settle lengths
    pulse_start();
    wait_neg(40);
    chk("lat_s1",     a_last - s_cyc, 17);
    chk("lat_s3",     b_last - s_cyc, 33);
    chk("word_s1",    int'(a_word), 8'h69);
    chk("word_s3",    int'(b_word), 8'h69);
    chk("busy_after", int'(a_busy | b_busy), 0);
    chk("one_done_a", a_cnt, 1);

    // start re-asserted mid-scan is ignored
    base_a = a_cnt;
    base_b = b_cnt;
    pulse_start();
    wait_neg(3);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_neg(40);
    chk("restart_ign_a", a_cnt - base_a, 1);
    chk("restart_ign_b", b_cnt - base_b, 1);

    // continuous back-to-back scans
    inp = 8'h5A;
    continuous = 1'b1;
    pulse_start();
    wait_neg(60);
    chk("cont_gap", a_gap, 17);
    chk("cont_busy", int'(b_busy | b_done), 1);
    continuous = 1'b0;
    wait_neg(45);
    chk("cont_word", int'(a_word), 8'h5A);
    chk("cont_idle", int'(a_busy | b_busy), 0);

    // reset at cycle 9 of a scan
    inp = 8'h69;
    base_a = a_cnt;
    pulse_start();
    wait_neg(7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sel",  int'(a_sel),  0);
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_word", int'(a_word), 8'h00);
    @(negedge clk) rst = 1'b0;
    wait_neg(40);
    chk("midrst_nodone", a_cnt - base_a, 0);
    chk("midrst_word2",  int'(a_word), 8'h00);

    // all ones, then all zeros
    inp = 8'hFF;
    pulse_start();
    wait_neg(40);
    chk("ones_a", int'(a_word), 8'hFF);
    chk("ones_b", int'(b_word), 8'hFF);
    inp = 8'h00;
    pulse_start();
    wait_neg(14);
    chk("zeros_hold", int'(a_word), 8'hFF);
    wait_neg(40);
    chk("zeros_a", int'(a_word), 8'h00);
    chk("zeros_b", int'(b_word), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
